// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and helpers for the ADC scan framer.
// Scan/frame FSM states, byte-index width, command field layout.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CWAIT,
    S_TXS,
    S_TXW
  } state_t;

  // Frame holds at most 3 + 2*8 = 19 bytes.
  localparam int BIDX_W = 5;
  localparam int CHI_W  = 4;

  localparam logic [7:0] HDR_DEF = 8'hA5;

  localparam int CMD_CH_LSB = 4;
  localparam int CMD_CH_MSB = 6;

  // Returned by next_ch when no enabled channel remains.
  localparam logic [CHI_W-1:0] CH_NONE = 4'd8;

  // Lowest enabled channel index >= from, or CH_NONE.
  function automatic logic [CHI_W-1:0] next_ch(
    input logic [7:0]       m,
    input logic [CHI_W-1:0] from
  );
    logic [CHI_W-1:0] r;
    r = CH_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (CHI_W'(i) >= from)) r = CHI_W'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/adc_scan_tx_trig.sv
// scan_trig: periodic tick counter plus button rising-edge detect.
// Emits a one-cycle trigger when either source fires.
module scan_trig #(
  parameter int PERIOD_W = 29
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_button,
  output logic                o_trig
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_btn;
  logic                w_run;
  logic                w_term;

  assign w_run  = i_en && (i_period != '0);
  assign w_term = (r_cnt >= i_period);
  assign o_trig = (w_run && w_term) || (i_button && !r_btn);

  // Free-running period counter and one-deep button history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_btn <= 1'b0;
    end else begin
      r_btn <= i_button;
      if (!w_run)      r_cnt <= '0;
      else if (w_term) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_tx.sv
// adc_scan_tx: multi-channel ADC scan sequencer and UART framer.
// Define ADC_SCAN_CSUM_EN to append a mod-256 checksum byte.
module adc_scan_tx
  import adc_scan_pkg::*;
#(
  parameter int         NCH      = 4,
  parameter int         PERIOD_W = 29,
  parameter logic [7:0] CMD_BASE = 8'b10010111,
  parameter logic [7:0] HDR      = HDR_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                button_i,
  input  logic [NCH-1:0]      ch_mask_i,
  output logic                strc_o,
  output logic [7:0]          cmd_o,
  input  logic                eoc_i,
  input  logic [11:0]         dout_i,
  output logic                st_o,
  output logic [7:0]          data_o,
  input  logic                eot_i,
  output logic                busy_o,
  output logic                eos_o,
  output logic                ovr_o
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t              r_state;
  state_t              w_nstate;
  logic                w_trig;
  logic [NCH-1:0]      r_mask;
  logic [CHI_W-1:0]    r_ch;
  logic [3:0]          r_cnt;
  logic [BIDX_W-1:0]   r_bidx;
  logic [BIDX_W-1:0]   w_last;
  logic                w_is_last;
  logic                r_strc;
  logic                r_st;
  logic                r_eos;
  logic [7:0]          r_cmd;
  logic [7:0]          r_data;
  logic                w_strc_n;
  logic                w_st_n;
  logic                w_eos_n;
  logic [7:0]          w_mask8;
  logic [7:0]          w_in8;
  logic [CHI_W-1:0]    w_nxt;
  logic [CHI_W-1:0]    w_first;
  logic [7:0]          w_cmd;
  logic [7:0]          w_byte;
  logic [11:0]         w_rd;
  logic [11:0]         r_buf [NCH];
`ifdef ADC_SCAN_CSUM_EN
  logic [7:0]          r_csum;
`endif

  scan_trig #(
    .PERIOD_W (PERIOD_W)
  ) u_trig (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_en     (en_i),
    .i_period (period_i),
    .i_button (button_i),
    .o_trig   (w_trig)
  );

  assign w_mask8 = 8'(r_mask);
  assign w_in8   = 8'(ch_mask_i);
  assign w_nxt   = next_ch(w_mask8, r_ch + 4'd1);
  assign w_first = next_ch(w_mask8, '0);
  assign w_rd    = r_buf[r_ch[CH_W-1:0]];

`ifdef ADC_SCAN_CSUM_EN
  assign w_last = BIDX_W'({r_cnt, 1'b0}) + BIDX_W'(2);
`else
  assign w_last = BIDX_W'({r_cnt, 1'b0}) + BIDX_W'(1);
`endif
  assign w_is_last = (r_bidx == w_last);

  // Channel index replaces the command's channel field.
  always_comb begin
    w_cmd = CMD_BASE;
    w_cmd[CMD_CH_MSB:CMD_CH_LSB] = r_ch[2:0];
  end

  // Byte selection: header, count, hi/lo sample pairs, checksum.
  always_comb begin
    w_byte = HDR;
    if (r_bidx == '0)
      w_byte = HDR;
    else if (r_bidx == BIDX_W'(1))
      w_byte = {4'h0, r_cnt};
`ifdef ADC_SCAN_CSUM_EN
    else if (w_is_last)
      w_byte = r_csum;
`endif
    else if (!r_bidx[0])
      w_byte = {r_ch, w_rd[11:8]};
    else
      w_byte = w_rd[7:0];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // Next state and next-cycle output pulses.
  always_comb begin
    w_nstate = r_state;
    w_strc_n = 1'b0;
    w_st_n   = 1'b0;
    w_eos_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig && (ch_mask_i != '0))
          w_nstate = S_CONV;
      end
      S_CONV: begin
        w_strc_n = 1'b1;
        w_nstate = S_CWAIT;
      end
      S_CWAIT: begin
        if (eoc_i)
          w_nstate = (w_nxt == CH_NONE) ? S_TXS : S_CONV;
      end
      S_TXS: begin
        w_st_n   = 1'b1;
        w_nstate = S_TXW;
      end
      S_TXW: begin
        if (eot_i) begin
          if (w_is_last) begin
            w_eos_n  = 1'b1;
            w_nstate = S_IDLE;
          end else begin
            w_nstate = S_TXS;
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Datapath: mask latch, channel walk, byte index, output regs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mask <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
      r_bidx <= '0;
      r_strc <= 1'b0;
      r_st   <= 1'b0;
      r_eos  <= 1'b0;
      r_cmd  <= '0;
      r_data <= '0;
`ifdef ADC_SCAN_CSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_strc <= w_strc_n;
      r_st   <= w_st_n;
      r_eos  <= w_eos_n;
      unique case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_mask <= ch_mask_i;
            r_ch   <= next_ch(w_in8, '0);
            r_cnt  <= pop8(w_in8);
            r_bidx <= '0;
`ifdef ADC_SCAN_CSUM_EN
            r_csum <= '0;
`endif
          end
        end
        S_CONV: r_cmd <= w_cmd;
        S_CWAIT: begin
          if (eoc_i) begin
            if (w_nxt == CH_NONE) begin
              r_ch   <= w_first;
              r_bidx <= '0;
            end else begin
              r_ch <= w_nxt;
            end
          end
        end
        S_TXS: begin
          r_data <= w_byte;
`ifdef ADC_SCAN_CSUM_EN
          if ((r_bidx != '0) && !w_is_last)
            r_csum <= r_csum + w_byte;
`endif
        end
        S_TXW: begin
          if (eot_i && !w_is_last) begin
            r_bidx <= r_bidx + 1'b1;
            if (r_bidx[0] && (r_bidx != BIDX_W'(1)))
              r_ch <= w_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample buffer; only entries of enabled channels are ever read.
  always_ff @(posedge clk_i) begin
    if ((r_state == S_CWAIT) && eoc_i)
      r_buf[r_ch[CH_W-1:0]] <= dout_i;
  end

  assign strc_o = r_strc;
  assign cmd_o  = r_cmd;
  assign st_o   = r_st;
  assign data_o = r_data;
  assign eos_o  = r_eos;
  assign busy_o = (r_state != S_IDLE) || r_eos;
  assign ovr_o  = !rst_i && w_trig && (r_state != S_IDLE);

endmodule
